// File: rtl/parity_frame_ctrl.sv
// Frames a serial bit stream into DATA_BITS data bits plus one parity bit and reports
// a per-frame pass/fail result, timeout aborts and a saturating error count.
module parity_frame_ctrl #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned ODD_PARITY = 0,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_valid,
    input  logic       data,
    output logic       busy,
    output logic       check,
    output logic       done,
    output logic       parity_err,
    output logic       timeout,
    output logic [7:0] err_cnt
);

    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] BLast = BW'(DATA_BITS - 1);
    localparam logic [TW-1:0] TLast = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          busy_q, busy_d;
    logic          check_q, check_d;
    logic          done_q, done_d;
    logic          parity_err_q, parity_err_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          frame_err;

    assign frame_err = check_q ^ data;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        timer_d      = timer_q;
        check_d      = check_q;
        done_d       = 1'b0;
        parity_err_d = parity_err_q;
        timeout_d    = timeout_q;
        err_cnt_d    = err_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StData;
                    check_d      = 1'(ODD_PARITY);
                    bit_cnt_d    = '0;
                    timer_d      = '0;
                    parity_err_d = 1'b0;
                    timeout_d    = 1'b0;
                end
            end
            StData: begin
                if (bit_valid) begin
                    check_d = check_q ^ data;
                    timer_d = '0;
                    if (bit_cnt_q == BLast) begin
                        state_d   = StParity;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (bit_valid) begin
                    parity_err_d = frame_err;
                    state_d      = StIdle;
                    done_d       = 1'b1;
                    timer_d      = '0;
                    if (frame_err && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A valid bit always wins over the idle timer.
        if ((state_q != StIdle) && !bit_valid && (TIMEOUT != 0)) begin
            if (timer_q == TLast) begin
                state_d      = StIdle;
                done_d       = 1'b1;
                timeout_d    = 1'b1;
                parity_err_d = 1'b0;
                timer_d      = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            timer_q      <= '0;
            busy_q       <= 1'b0;
            check_q      <= 1'b0;
            done_q       <= 1'b0;
            parity_err_q <= 1'b0;
            timeout_q    <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            timer_q      <= timer_d;
            busy_q       <= busy_d;
            check_q      <= check_d;
            done_q       <= done_d;
            parity_err_q <= parity_err_d;
            timeout_q    <= timeout_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign busy       = busy_q;
    assign check      = check_q;
    assign done       = done_q;
    assign parity_err = parity_err_q;
    assign timeout    = timeout_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed bench for parity_frame_ctrl; an even-parity and an odd-parity instance
// share the same stimulus.
module tb_parity_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, bit_valid, data;
    logic       busy_e, check_e, done_e, perr_e, to_e;
    logic [7:0] cnt_e;
    logic       busy_o, check_o, done_o, perr_o, to_o;
    logic [7:0] cnt_o;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    parity_frame_ctrl #(.DATA_BITS(8), .ODD_PARITY(0), .TIMEOUT(16)) dut_even (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .data(data),
        .busy(busy_e), .check(check_e), .done(done_e), .parity_err(perr_e),
        .timeout(to_e), .err_cnt(cnt_e)
    );

    parity_frame_ctrl #(.DATA_BITS(8), .ODD_PARITY(1), .TIMEOUT(16)) dut_odd (
        .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .data(data),
        .busy(busy_o), .check(check_o), .done(done_o), .parity_err(perr_o),
        .timeout(to_o), .err_cnt(cnt_o)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        data      = b;
        tick();
        bit_valid = 1'b0;
        data      = 1'b0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic frame(input logic [7:0] d, input logic p);
        start_frame();
        send_byte(d);
        send_bit(p);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; data = 1'b0;
        #12;
        chk("rst_busy", {7'd0, busy_e}, 8'd0);
        chk("rst_check", {7'd0, check_e}, 8'd0);
        chk("rst_done", {7'd0, done_e}, 8'd0);
        chk("rst_perr", {7'd0, perr_e}, 8'd0);
        chk("rst_timeout", {7'd0, to_e}, 8'd0);
        chk("rst_cnt", cnt_e, 8'd0);
        tick();
        rst = 1'b0;
        tick();

        // Clean even frame 0xA5, parity 0
        start_frame();
        chk("t1_busy_rise", {7'd0, busy_e}, 8'd1);
        chk("t1_check_seed", {7'd0, check_e}, 8'd0);
        chk("t1_check_seed_odd", {7'd0, check_o}, 8'd1);
        send_bit(1'b1);
        chk("t1_check_bit0", {7'd0, check_e}, 8'd1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("t1_check_data", {7'd0, check_e}, 8'd0);
        chk("t1_no_done_yet", {7'd0, done_e}, 8'd0);
        send_bit(1'b0);
        chk("t1_done", {7'd0, done_e}, 8'd1);
        chk("t1_busy_fall", {7'd0, busy_e}, 8'd0);
        chk("t1_perr", {7'd0, perr_e}, 8'd0);
        chk("t1_cnt", cnt_e, 8'd0);
        tick();
        chk("t1_done_pulse", {7'd0, done_e}, 8'd0);

        // Same frame, wrong parity
        frame(8'hA5, 1'b1);
        chk("t2_done", {7'd0, done_e}, 8'd1);
        chk("t2_perr", {7'd0, perr_e}, 8'd1);
        chk("t2_cnt", cnt_e, 8'd1);

        // 0x01 frames: odd instance passes with parity 0, fails with 1
        frame(8'h01, 1'b0);
        chk("t3_odd_p0", {7'd0, perr_o}, 8'd0);
        chk("t3_even_p0", {7'd0, perr_e}, 8'd1);
        chk("t3_even_cnt", cnt_e, 8'd2);
        frame(8'h01, 1'b1);
        chk("t3_odd_p1", {7'd0, perr_o}, 8'd1);
        chk("t3_even_p1", {7'd0, perr_e}, 8'd0);
        chk("t3_even_cnt2", cnt_e, 8'd2);

        // Timeout after 3 bits and 16 idle cycles
        start_frame();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        repeat (15) tick();
        chk("t4_busy_15", {7'd0, busy_e}, 8'd1);
        chk("t4_done_15", {7'd0, done_e}, 8'd0);
        tick();
        chk("t4_done", {7'd0, done_e}, 8'd1);
        chk("t4_timeout", {7'd0, to_e}, 8'd1);
        chk("t4_perr", {7'd0, perr_e}, 8'd0);
        chk("t4_busy", {7'd0, busy_e}, 8'd0);
        chk("t4_cnt", cnt_e, 8'd2);
        tick();
        chk("t4_done_pulse", {7'd0, done_e}, 8'd0);
        chk("t4_timeout_held", {7'd0, to_e}, 8'd1);

        // Bit arriving on the 16th idle cycle beats the timeout
        start_frame();
        chk("t5_timeout_clr", {7'd0, to_e}, 8'd0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        repeat (15) tick();
        send_bit(1'b0);
        chk("t5_busy", {7'd0, busy_e}, 8'd1);
        chk("t5_no_done", {7'd0, done_e}, 8'd0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        chk("t5_busy2", {7'd0, busy_e}, 8'd1);
        send_bit(1'b1);
        chk("t5_done", {7'd0, done_e}, 8'd1);
        chk("t5_timeout", {7'd0, to_e}, 8'd0);
        chk("t5_perr", {7'd0, perr_e}, 8'd0);

        // start pulsed with data bit 4 is ignored
        start_frame();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bit_valid = 1'b1; data = 1'b0; start = 1'b1;
        tick();
        bit_valid = 1'b0; start = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("t6_busy", {7'd0, busy_e}, 8'd1);
        send_bit(1'b0);
        chk("t6_done", {7'd0, done_e}, 8'd1);
        chk("t6_perr", {7'd0, perr_e}, 8'd0);

        // start while done is high opens a new frame
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t7_busy", {7'd0, busy_e}, 8'd1);
        chk("t7_done_low", {7'd0, done_e}, 8'd0);
        send_byte(8'hA5);
        send_bit(1'b0);
        chk("t7_done", {7'd0, done_e}, 8'd1);
        chk("t7_perr", {7'd0, perr_e}, 8'd0);
        chk("t7_cnt", cnt_e, 8'd2);

        // Error counter saturation
        repeat (260) frame(8'hA5, 1'b1);
        chk("t8_cnt_sat", cnt_e, 8'd255);
        chk("t8_perr", {7'd0, perr_e}, 8'd1);

        // Asynchronous reset mid-frame
        start_frame();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        chk("t9_check_pre", {7'd0, check_e}, 8'd1);
        #3 rst = 1'b1;
        #1;
        chk("t9_busy", {7'd0, busy_e}, 8'd0);
        chk("t9_check", {7'd0, check_e}, 8'd0);
        chk("t9_done", {7'd0, done_e}, 8'd0);
        chk("t9_perr", {7'd0, perr_e}, 8'd0);
        chk("t9_timeout", {7'd0, to_e}, 8'd0);
        chk("t9_cnt", cnt_e, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t9_done_after", {7'd0, done_e}, 8'd0);
        chk("t9_busy_after", {7'd0, busy_e}, 8'd0);
        frame(8'h0F, 1'b0);
        chk("t9_frame_done", {7'd0, done_e}, 8'd1);
        chk("t9_frame_perr", {7'd0, perr_e}, 8'd0);
        chk("t9_frame_cnt", cnt_e, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
